// File: rtl/cell_box_painter.sv
// cell_box_painter
//
// Responder side of the draw-request handshake. A one-cycle start pulse
// latches a top-left origin and a fill colour. The block then streams every
// pixel of one BOX_W x BOX_H board cell, in raster order, as single-pixel
// writes to the framebuffer write port. It finishes with a one-cycle done
// pulse.
//
// Ports:
//   CLOCK_50    system clock
//   resetn      asynchronous active-low reset
//   start       draw request, sampled only when idle or in the finish cycle
//   x0, y0      box origin in pixels
//   color       fill colour (3R/3G/3B)
//   plot_ready  framebuffer accepts the presented pixel this cycle
//   busy        a box is in progress
//   done        one-cycle completion pulse
//   pix_x/pix_y pixel write address (registered)
//   pix_color   pixel write colour (registered)
//   pix_plot    pixel write valid (registered)
module cell_box_painter #(
  parameter int BOX_W   = 64,
  parameter int BOX_H   = 24,
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int COLOR_W = 9
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic [9:0]         x0,
  input  logic [8:0]         y0,
  input  logic [COLOR_W-1:0] color,
  input  logic               plot_ready,
  output logic               busy,
  output logic               done,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_plot
);

  localparam int CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Limits are one bit wider than the pixel address, so an origin near the
  // screen edge plus the cell offset shows up as out of range rather than
  // wrapping back onto the visible screen.
  localparam logic [10:0]     X_LIM   = 11'(X_MAX);
  localparam logic [9:0]      Y_LIM   = 10'(Y_MAX);
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

  logic [1:0]         r_state;
  logic [CX_W-1:0]    r_cx;
  logic [CY_W-1:0]    r_cy;
  logic [9:0]         r_x0;
  logic [8:0]         r_y0;
  logic [COLOR_W-1:0] r_color;
  logic               r_busy;
  logic               r_done;
  logic [9:0]         r_pix_x;
  logic [8:0]         r_pix_y;
  logic               r_pix_plot;

  logic               w_accept;
  logic               w_adv;
  logic               w_last;
  logic [CX_W-1:0]    w_ncx;
  logic [CY_W-1:0]    w_ncy;
  logic [9:0]         w_base_x;
  logic [8:0]         w_base_y;
  logic [CX_W-1:0]    w_off_x;
  logic [CY_W-1:0]    w_off_y;
  logic [10:0]        w_sum_x;
  logic [9:0]         w_sum_y;
  logic               w_in_range;

  // Next-pixel selection: either the first pixel of a newly accepted box or
  // the raster successor of the pixel currently presented.
  always_comb begin
    w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    // A clipped pixel is presented with pix_plot low and never waits for
    // the framebuffer, so it advances after exactly one cycle.
    w_adv    = (r_state == ST_DRAW) && (!r_pix_plot || plot_ready);
    w_last   = (r_cx == CX_LAST) && (r_cy == CY_LAST);

    if (r_cx == CX_LAST) begin
      w_ncx = '0;
      w_ncy = r_cy + CY_W'(1);
    end else begin
      w_ncx = r_cx + CX_W'(1);
      w_ncy = r_cy;
    end

    if (w_accept) begin
      w_base_x = x0;
      w_base_y = y0;
      w_off_x  = '0;
      w_off_y  = '0;
    end else begin
      w_base_x = r_x0;
      w_base_y = r_y0;
      w_off_x  = w_ncx;
      w_off_y  = w_ncy;
    end

    w_sum_x    = {1'b0, w_base_x} + 11'(w_off_x);
    w_sum_y    = {1'b0, w_base_y} + 10'(w_off_y);
    w_in_range = (w_sum_x < X_LIM) && (w_sum_y < Y_LIM);
  end

  // Sequencer: latches requests, walks the raster, and drives all outputs
  // from registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_x0       <= 10'd0;
      r_y0       <= 9'd0;
      r_color    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pix_x    <= 10'd0;
      r_pix_y    <= 9'd0;
      r_pix_plot <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FIN: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= ST_DRAW;
            r_cx       <= '0;
            r_cy       <= '0;
            r_x0       <= x0;
            r_y0       <= y0;
            r_color    <= color;
            r_busy     <= 1'b1;
            r_pix_x    <= w_sum_x[9:0];
            r_pix_y    <= w_sum_y[8:0];
            r_pix_plot <= w_in_range;
          end else begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_pix_plot <= 1'b0;
          end
        end
        ST_DRAW: begin
          // A stalled in-range pixel keeps every output register unchanged.
          if (w_adv) begin
            if (w_last) begin
              r_state    <= ST_FIN;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pix_plot <= 1'b0;
            end else begin
              r_cx       <= w_ncx;
              r_cy       <= w_ncy;
              r_pix_x    <= w_sum_x[9:0];
              r_pix_y    <= w_sum_y[8:0];
              r_pix_plot <= w_in_range;
            end
          end else begin
            r_state <= ST_DRAW;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_pix_plot <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_color = r_color;
  assign pix_plot  = r_pix_plot;

endmodule

// File: tb/tb_cell_box_painter.sv
// Self-checking bench for cell_box_painter. The reference model enumerates
// the cell pixels with nested loops and screen-limit arithmetic. It derives
// the completion cycle by walking the ready pattern that the bench applies.
module tb_cell_box_painter;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x0 = 10'd0;
  logic [8:0] y0 = 9'd0;
  logic [8:0] color = 9'd0;
  logic       plot_ready = 1'b0;
  logic       busy, done, pix_plot;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [8:0] pix_color;

  always #10 CLOCK_50 = ~CLOCK_50;

  cell_box_painter dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .color     (color),
    .plot_ready(plot_ready),
    .busy      (busy),
    .done      (done),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_plot  (pix_plot)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t obs_q[$];
  pix_t exp_q[$];
  int   obs_cyc[$];
  int   done_cyc[$];
  bit   ready_tab[0:8191];
  int   hold_viol, overlap_viol, busy_cnt;
  int   n_checks = 0;
  int   n_pass = 0;

  // Ready pattern indexed by the cycle number after start: 0 = always
  // ready, 1 = 1,0,1,0..., 2 = random (mostly ready).
  function automatic void fill_ready(input int mode);
    for (int i = 0; i < 8192; i++) begin
      case (mode)
        0:       ready_tab[i] = 1'b1;
        1:       ready_tab[i] = (i % 2 == 1);
        default: ready_tab[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endfunction

  // Append the expected writes of one box, in raster order, to exp_q.
  function automatic void model_box(input int bx, input int by, input int c);
    int   px, py;
    pix_t p;
    for (int cy = 0; cy < 24; cy++) begin
      for (int cx = 0; cx < 64; cx++) begin
        px = bx + cx;
        py = by + cy;
        if (px < 640 && py < 480) begin
          p.x = 10'(px);
          p.y = 9'(py);
          p.c = 9'(c);
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  // Cycle in which done is expected. A clipped pixel costs one cycle. An
  // in-range pixel waits for a ready cycle and is accepted in that cycle.
  function automatic int model_done(input int bx, input int by, input int first);
    int cyc;
    cyc = first;
    for (int cy = 0; cy < 24; cy++) begin
      for (int cx = 0; cx < 64; cx++) begin
        if (bx + cx >= 640 || by + cy >= 480) begin
          cyc++;
        end else begin
          while (cyc < 8191 && !ready_tab[cyc]) cyc++;
          cyc++;
        end
      end
    end
    return cyc;
  endfunction

  // Count positions where the observed writes differ from the expected ones.
  function automatic int diff_count();
    int d, n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                      : exp_q.size() - obs_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  // Pulse start with the given origin and colour. Afterwards the inputs
  // are scrambled to show that they are latched.
  task automatic kick(input int bx, input int by, input int c);
    start = 1'b1;
    x0 = 10'(bx);
    y0 = 9'(by);
    color = 9'(c);
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    x0 = 10'($urandom);
    y0 = 9'($urandom);
    color = 9'($urandom);
  endtask

  // Record accepted writes, done pulses and protocol violations, cycle by
  // cycle, starting at cycle t+1.
  task automatic observe(input int want_done, input int inj_at, input bit b2b,
                         input int bx, input int by, input int c,
                         input int max_cycles, output bit timeout);
    int   cyc, nd;
    bit   prev_stall, prev_done;
    pix_t p, prev_p;
    obs_q.delete(); obs_cyc.delete(); done_cyc.delete();
    hold_viol = 0; overlap_viol = 0; busy_cnt = 0;
    cyc = 1; nd = 0; prev_stall = 1'b0; prev_done = 1'b0; prev_p = '0;
    while (nd < want_done && cyc < max_cycles) begin
      start = 1'b0;
      plot_ready = ready_tab[cyc];
      p.x = pix_x; p.y = pix_y; p.c = pix_color;
      if (busy && done) overlap_viol++;
      if (done && prev_done) overlap_viol++;
      if (prev_stall && (!pix_plot || p !== prev_p)) hold_viol++;
      if (busy) busy_cnt++;
      if (pix_plot && plot_ready) begin
        obs_q.push_back(p);
        obs_cyc.push_back(cyc);
      end
      prev_stall = pix_plot && !plot_ready;
      prev_p = p;
      prev_done = done;
      if (cyc == inj_at) begin
        start = 1'b1; x0 = 10'd0; y0 = 9'd0; color = 9'h0AA;
      end
      if (done) begin
        nd++;
        done_cyc.push_back(cyc);
        if (b2b && nd < want_done) begin
          start = 1'b1; x0 = 10'(bx); y0 = 9'(by); color = 9'(c);
        end
      end
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    start = 1'b0;
    timeout = (nd < want_done);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if ({busy, done, pix_plot} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, done, pix_plot});
    else n_pass++;
    n_checks++;
    if (pix_x !== 10'd0) $display("FAIL reset_pix_x: got %0d want 0", pix_x);
    else n_pass++;
    n_checks++;
    if (pix_y !== 9'd0) $display("FAIL reset_pix_y: got %0d want 0", pix_y);
    else n_pass++;
    n_checks++;
    if (pix_color !== 9'd0) $display("FAIL reset_pix_color: got %h want 0", pix_color);
    else n_pass++;
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_basic();
    bit   to;
    pix_t e_first, e_last;
    int   dc;
    e_first = pix_t'{10'd64, 9'd48, 9'h1C7};
    e_last  = pix_t'{10'd127, 9'd71, 9'h1C7};
    fill_ready(0);
    exp_q.delete();
    model_box(64, 48, 'h1C7);
    kick(64, 48, 'h1C7);
    observe(1, 0, 1'b0, 0, 0, 0, 4000, to);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_checks++;
    if (to !== 1'b0) $display("FAIL basic_timeout: no done within budget");
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 1536) $display("FAIL basic_writes: got %0d want 1536", obs_q.size());
    else n_pass++;
    n_checks++;
    if (diff_count() !== 0) $display("FAIL basic_pixels: %0d mismatched writes, want 0", diff_count());
    else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== e_first) $display("FAIL basic_first: first write wrong, want (64,48,1C7)");
    else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[$] !== e_last) $display("FAIL basic_last: last write wrong, want (127,71,1C7)");
    else n_pass++;
    n_checks++;
    if (dc !== 1537) $display("FAIL basic_done_cycle: got %0d want 1537", dc);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 1536) $display("FAIL basic_busy_cycles: got %0d want 1536", busy_cnt);
    else n_pass++;
    n_checks++;
    if (overlap_viol !== 0) $display("FAIL basic_busy_done: got %0d violations want 0", overlap_viol);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    int dc;
    fill_ready(1);
    exp_q.delete();
    model_box(64, 48, 'h1C7);
    kick(64, 48, 'h1C7);
    observe(1, 0, 1'b0, 0, 0, 0, 8000, to);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_checks++;
    if (obs_q.size() !== 1536) $display("FAIL bp_writes: got %0d want 1536", obs_q.size());
    else n_pass++;
    n_checks++;
    if (diff_count() !== 0) $display("FAIL bp_pixels: %0d mismatched writes, want 0", diff_count());
    else n_pass++;
    n_checks++;
    if (hold_viol !== 0) $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_viol);
    else n_pass++;
    n_checks++;
    if (dc !== model_done(64, 48, 1)) $display("FAIL bp_done_cycle: got %0d want %0d", dc, model_done(64, 48, 1));
    else n_pass++;
    fill_ready(0);
  endtask

  task automatic test_clipping();
    bit to;
    int dc;
    fill_ready(0);
    exp_q.delete();
    model_box(600, 470, 'h03F);
    kick(600, 470, 'h03F);
    observe(1, 0, 1'b0, 0, 0, 0, 4000, to);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_checks++;
    if (obs_q.size() !== 400) $display("FAIL clip_writes: got %0d want 400", obs_q.size());
    else n_pass++;
    n_checks++;
    if (diff_count() !== 0) $display("FAIL clip_pixels: %0d mismatched writes, want 0", diff_count());
    else n_pass++;
    n_checks++;
    if (dc !== 1537) $display("FAIL clip_done_cycle: got %0d want 1537", dc);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 1536) $display("FAIL clip_busy_cycles: got %0d want 1536", busy_cnt);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit to;
    int extra;
    fill_ready(0);
    exp_q.delete();
    model_box(64, 48, 'h155);
    kick(64, 48, 'h155);
    observe(1, 101, 1'b0, 0, 0, 0, 4000, to);
    n_checks++;
    if (diff_count() !== 0) $display("FAIL swb_pixels: %0d mismatched writes, want 0", diff_count());
    else n_pass++;
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 1537) $display("FAIL swb_done: got %0d pulses want 1 at 1537", done_cyc.size());
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done || pix_plot) extra++;
      @(posedge CLOCK_50); #1;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL swb_queued: got %0d active cycles after done want 0", extra);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit   to;
    pix_t e2;
    int   d0, d1, c2;
    e2 = pix_t'{10'd128, 9'd0, 9'h0F0};
    fill_ready(0);
    exp_q.delete();
    model_box(64, 48, 'h1C7);
    model_box(128, 0, 'h0F0);
    kick(64, 48, 'h1C7);
    observe(2, 0, 1'b1, 128, 0, 'h0F0, 8000, to);
    d0 = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    d1 = (done_cyc.size() > 1) ? done_cyc[1] : -1;
    c2 = (obs_cyc.size() > 1536) ? obs_cyc[1536] : -1;
    n_checks++;
    if (obs_q.size() !== 3072) $display("FAIL b2b_writes: got %0d want 3072", obs_q.size());
    else n_pass++;
    n_checks++;
    if (diff_count() !== 0) $display("FAIL b2b_pixels: %0d mismatched writes, want 0", diff_count());
    else n_pass++;
    n_checks++;
    if (d0 !== 1537 || d1 !== 3074) $display("FAIL b2b_done: got %0d,%0d want 1537,3074", d0, d1);
    else n_pass++;
    n_checks++;
    if (c2 !== 1538 || obs_q.size() <= 1536 || obs_q[1536] !== e2) $display("FAIL b2b_first_pixel: cycle %0d want 1538 at (128,0)", c2);
    else n_pass++;
    n_checks++;
    if (overlap_viol !== 0) $display("FAIL b2b_busy_done: got %0d violations want 0", overlap_viol);
    else n_pass++;
  endtask

  task automatic test_reset_mid_box();
    bit to, saw;
    int dc;
    fill_ready(0);
    kick(64, 48, 'h1C7);
    for (int i = 1; i < 501; i++) begin
      plot_ready = 1'b1;
      @(posedge CLOCK_50); #1;
    end
    n_checks++;
    if ({busy, pix_plot} !== 2'b11) $display("FAIL rst_mid_active: got %b want 11", {busy, pix_plot});
    else n_pass++;
    #3 resetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, pix_plot, done} !== 3'b000) $display("FAIL rst_mid_async: got %b want 000", {busy, pix_plot, done});
    else n_pass++;
    saw = 1'b0;
    repeat (3) begin
      @(posedge CLOCK_50); #1;
      if (done) saw = 1'b1;
    end
    resetn = 1'b1;
    repeat (5) begin
      @(posedge CLOCK_50); #1;
      if (done || busy) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL rst_mid_no_done: got activity after reset want none");
    else n_pass++;
    exp_q.delete();
    model_box(10, 20, 'h0C3);
    kick(10, 20, 'h0C3);
    observe(1, 0, 1'b0, 0, 0, 0, 4000, to);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_checks++;
    if (obs_q.size() !== 1536 || diff_count() !== 0) $display("FAIL rst_mid_redraw: got %0d writes want 1536 matching", obs_q.size());
    else n_pass++;
    n_checks++;
    if (dc !== 1537) $display("FAIL rst_mid_redraw_done: got %0d want 1537", dc);
    else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    int bx, by, c, dc, md;
    for (int it = 0; it < 3; it++) begin
      bx = (it == 0) ? $urandom_range(580, 1023) : $urandom_range(0, 1023);
      by = (it == 0) ? $urandom_range(460, 511) : $urandom_range(0, 511);
      c = $urandom_range(0, 511);
      fill_ready(2);
      exp_q.delete();
      model_box(bx, by, c);
      md = model_done(bx, by, 1);
      kick(bx, by, c);
      observe(1, 0, 1'b0, 0, 0, 0, 8000, to);
      dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      n_checks++;
      if (diff_count() !== 0) $display("FAIL rand_pixels: origin (%0d,%0d) %0d mismatched writes want 0", bx, by, diff_count());
      else n_pass++;
      n_checks++;
      if (dc !== md) $display("FAIL rand_done_cycle: origin (%0d,%0d) got %0d want %0d", bx, by, dc, md);
      else n_pass++;
      n_checks++;
      if (hold_viol !== 0) $display("FAIL rand_hold: got %0d unstable stalls want 0", hold_viol);
      else n_pass++;
    end
    fill_ready(0);
  endtask

  initial begin
    fill_ready(0);
    test_reset();
    test_basic();
    test_backpressure();
    test_clipping();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_box();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
